lfsr_rng_arbiter: RTL and testbench

//   Shares one free-running 128-bit XNOR LFSR (taps 128,126,101,99) between N_REQ requesters.

---
 rtl/lfsr_rng_arbiter.sv | 103 ++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_arbiter.sv
// Shared 128-bit XNOR LFSR (taps 128,126,101,99) serving N_REQ requesters through a
// round-robin req/gnt handshake, with seeding, warm-up and a post-grant gap.
module lfsr_rng_arbiter #(
   parameter int           N_REQ         = 4,
   parameter logic [127:0] INIT_VALUE    = 128'h001bb69a_baf65811_caa417d1_19362a08,
   parameter int           WARMUP_CYCLES = 128,
   parameter int           GAP_CYCLES    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_valid,
   input  logic [127:0]     seed_data,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [31:0]      rdata,
   output logic             rng_ready
);
   localparam int CNT_MAX = (WARMUP_CYCLES > GAP_CYCLES) ? WARMUP_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {S_WARMUP, S_SERVE, S_GAP} state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [127:0]     r_lfsr, w_lfsr_step;
   logic [RW-1:0]    r_rr, w_win_idx, w_rr_nxt;
   logic [N_REQ-1:0] w_rot, r_gnt;
   logic [31:0]      r_rdata;
   logic             w_win_vld, w_grant;

   assign w_lfsr_step = {r_lfsr[126:0], ~(r_lfsr[127] ^ r_lfsr[125] ^ r_lfsr[100] ^ r_lfsr[98])};

   // Rotate requests so bit 0 is the current highest-priority requester.
   assign w_rot = N_REQ'({req, req} >> r_rr);

   always_comb begin
      w_win_vld = 1'b0;
      w_win_idx = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_win_vld = 1'b1;
            w_win_idx = RW'((int'(r_rr) + j) % N_REQ);
         end
      end
   end

   assign w_rr_nxt = (int'(w_win_idx) == N_REQ - 1) ? '0 : w_win_idx + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant     = 1'b0;
      case (r_state)
         S_SERVE: begin
            if (w_win_vld) begin
               w_grant = 1'b1;
               if (GAP_CYCLES > 0) begin
                  w_state_nxt = S_GAP;
                  w_cnt_nxt   = CW'(GAP_CYCLES);
               end
            end
         end
         default: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt <= CW'(1)) begin
               w_state_nxt = S_SERVE;
               w_cnt_nxt   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr  <= INIT_VALUE;
         r_state <= S_WARMUP;
         r_cnt   <= CW'(WARMUP_CYCLES);
         r_rr    <= '0;
         r_gnt   <= '0;
         r_rdata <= '0;
      end else if (seed_valid) begin
         // All-ones is the XNOR lockup state; fall back to the reset value.
         r_lfsr  <= (&seed_data) ? INIT_VALUE : seed_data;
         r_state <= S_WARMUP;
         r_cnt   <= CW'(WARMUP_CYCLES);
         r_gnt   <= '0;
      end else begin
         r_lfsr  <= w_lfsr_step;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt   <= w_grant ? (N_REQ'(1) << w_win_idx) : '0;
         if (w_grant) begin
            r_rdata <= r_lfsr[31:0];
            r_rr    <= w_rr_nxt;
         end
      end
   end

   assign gnt       = r_gnt;
   assign rdata     = r_rdata;
   assign rng_ready = (r_state == S_SERVE);
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: directed scenarios plus a long random run against a
// countdown-based reference model (instance a: WARMUP=4 GAP=3, instance b: WARMUP=1 GAP=0).
module tb_lfsr_rng_arbiter;
   localparam logic [127:0] INIT = 128'h001bb69a_baf65811_caa417d1_19362a08;

   typedef struct {
      logic [127:0] lfsr;
      int           wait_n;
      int           rr;
      logic [3:0]   gnt;
      logic [31:0]  rdata;
   } mdl_t;

   logic clk = 1'b0;
   logic rst_na, sv_a, rst_nb, sv_b;
   logic [127:0] sd_a, sd_b;
   logic [3:0] req_a, req_b, gnt_a, gnt_b;
   logic [31:0] rdata_a, rdata_b;
   logic rdy_a, rdy_b;
   int nerr = 0, nchk = 0;
   mdl_t ma, mb;

   always #5 clk = ~clk;

   lfsr_rng_arbiter #(.N_REQ(4), .INIT_VALUE(INIT), .WARMUP_CYCLES(4), .GAP_CYCLES(3)) dut_a (
      .clk(clk), .rst_n(rst_na), .seed_valid(sv_a), .seed_data(sd_a), .req(req_a),
      .gnt(gnt_a), .rdata(rdata_a), .rng_ready(rdy_a));
   lfsr_rng_arbiter #(.N_REQ(4), .INIT_VALUE(INIT), .WARMUP_CYCLES(1), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_nb), .seed_valid(sv_b), .seed_data(sd_b), .req(req_b),
      .gnt(gnt_b), .rdata(rdata_b), .rng_ready(rdy_b));

   function automatic mdl_t mreset(int w);
      mdl_t s;
      s.lfsr = INIT; s.wait_n = w; s.rr = 0; s.gnt = '0; s.rdata = '0;
      return s;
   endfunction

   // wait_n = steps remaining until words may be served; 0 means serving.
   function automatic mdl_t mstep(mdl_t s, logic sv, logic [127:0] sd, logic [3:0] rq, int w, int g);
      mdl_t n = s;
      logic found = 1'b0;
      n.gnt = '0;
      if (sv) begin
         n.lfsr = (sd === {128{1'b1}}) ? INIT : sd;
         n.wait_n = w;
         return n;
      end
      n.lfsr = {s.lfsr[126:0], ~(s.lfsr[127] ^ s.lfsr[125] ^ s.lfsr[100] ^ s.lfsr[98])};
      if (s.wait_n == 0) begin
         for (int k = 0; k < 4; k++) begin
            if (!found && rq[(s.rr + k) % 4]) begin
               found = 1'b1;
               n.gnt[(s.rr + k) % 4] = 1'b1;
               n.rdata = s.lfsr[31:0];
               n.rr = (s.rr + k + 1) % 4;
               n.wait_n = g;
            end
         end
      end else begin
         n.wait_n = s.wait_n - 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_na)
      if (!rst_na) ma = mreset(4); else ma = mstep(ma, sv_a, sd_a, req_a, 4, 3);
   always @(posedge clk or negedge rst_nb)
      if (!rst_nb) mb = mreset(1); else mb = mstep(mb, sv_b, sd_b, req_b, 1, 0);

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic test_reset();
      rst_na = 0; rst_nb = 0; sv_a = 0; sv_b = 0; sd_a = '0; sd_b = '0; req_a = '0; req_b = '0;
      repeat (2) @(negedge clk);
      nchk++;
      if ({gnt_a, rdata_a, rdy_a} !== 37'd0) begin
         nerr++; $display("FAIL reset_state got gnt=%b rdata=%h rdy=%b exp all 0", gnt_a, rdata_a, rdy_a);
      end
      rst_na = 1; rst_nb = 1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         nchk++;
         if (rdy_a !== (k >= 4) || gnt_a !== 4'b0) begin
            nerr++; $display("FAIL warmup k=%0d got rdy=%b gnt=%b exp rdy=%b gnt=0000", k, rdy_a, gnt_a, k >= 4);
         end
      end
   endtask

   task automatic test_seed_zero();
      sv_a = 1; sd_a = '0; req_a = 4'b0001;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         nchk++;
         if (rdy_a !== (k == 5 || k == 9) || gnt_a !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
            nerr++;
            $display("FAIL seed0_seq k=%0d got rdy=%b gnt=%b exp rdy=%b gnt=%b", k, rdy_a, gnt_a,
                     (k == 5 || k == 9), (k == 6) ? 4'b0001 : 4'b0000);
         end
         if (k == 6) begin
            nchk++;
            if (rdata_a !== 32'h0000000F) begin
               nerr++; $display("FAIL seed0_rdata got %h exp 0000000f", rdata_a);
            end
            req_a = '0;
         end
         if (k == 1) sv_a = 0;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [31:0] er [5] = '{32'h1, 32'h3, 32'h7, 32'hF, 32'h1F};
      sv_b = 1; sd_b = '0; req_b = 4'b1111;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) sv_b = 0;
         nchk++;
         if (rdy_b !== (k >= 2)) begin
            nerr++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, rdy_b, k >= 2);
         end
         if (k >= 3) begin
            nchk++;
            if (gnt_b !== eg[k-3] || rdata_b !== er[k-3]) begin
               nerr++; $display("FAIL b2b_grant k=%0d got gnt=%b rdata=%h exp gnt=%b rdata=%h",
                                k, gnt_b, rdata_b, eg[k-3], er[k-3]);
            end
         end
      end
      req_b = '0;
   endtask

   task automatic test_seed_lockup();
      logic [127:0] l = INIT;
      logic got = 0;
      repeat (4) l = {l[126:0], ~(l[127] ^ l[125] ^ l[100] ^ l[98])};
      sv_a = 1; sd_a = '1; req_a = 4'b0010;
      for (int k = 1; k <= 20 && !got; k++) begin
         @(negedge clk);
         sv_a = 0;
         if (gnt_a !== 4'b0) begin
            got = 1; req_a = '0;
            nchk++;
            if (k != 6 || gnt_a !== 4'b0010 || rdata_a !== l[31:0]) begin
               nerr++; $display("FAIL lockup_seed k=%0d got gnt=%b rdata=%h exp k=6 gnt=0010 rdata=%h",
                                k, gnt_a, rdata_a, l[31:0]);
            end
         end
      end
      if (!got) begin nchk++; nerr++; $display("FAIL lockup_seed timeout got no gnt exp gnt=0010"); end
   endtask

   task automatic test_seed_vs_req();
      logic got = 0;
      for (int k = 0; k < 20 && !rdy_a; k++) @(negedge clk);
      sv_a = 1; sd_a = rnd128(); req_a = 4'b0100;
      @(negedge clk);
      sv_a = 0;
      nchk++;
      if (gnt_a !== 4'b0 || rdy_a !== 1'b0) begin
         nerr++; $display("FAIL seed_beats_req got gnt=%b rdy=%b exp gnt=0000 rdy=0", gnt_a, rdy_a);
      end
      for (int j = 1; j <= 10 && !got; j++) begin
         @(negedge clk);
         if (gnt_a !== 4'b0) begin
            got = 1; req_a = '0;
            nchk++;
            if (j != 5 || gnt_a !== 4'b0100 || rdata_a !== ma.rdata) begin
               nerr++; $display("FAIL seed_restart j=%0d got gnt=%b rdata=%h exp j=5 gnt=0100 rdata=%h",
                                j, gnt_a, rdata_a, ma.rdata);
            end
         end
      end
      if (!got) begin nchk++; nerr++; $display("FAIL seed_restart timeout got no gnt exp gnt=0100"); end
   endtask

   task automatic test_reset_mid_gap();
      logic got = 0;
      for (int k = 0; k < 20 && !rdy_a; k++) @(negedge clk);
      req_a = 4'b0010;
      for (int k = 0; k < 10 && gnt_a === 4'b0; k++) @(negedge clk);
      req_a = 4'b1000;
      #2 rst_na = 0;
      #1;
      nchk++;
      if ({gnt_a, rdata_a, rdy_a} !== 37'd0) begin
         nerr++; $display("FAIL async_reset got gnt=%b rdata=%h rdy=%b exp all 0", gnt_a, rdata_a, rdy_a);
      end
      @(negedge clk);
      rst_na = 1; req_a = 4'b1111;
      for (int k = 1; k <= 10 && !got; k++) begin
         @(negedge clk);
         if (gnt_a !== 4'b0) begin
            got = 1; req_a = '0;
            nchk++;
            if (k != 5 || gnt_a !== 4'b0001) begin
               nerr++; $display("FAIL rr_after_reset k=%0d got gnt=%b exp k=5 gnt=0001", k, gnt_a);
            end
         end
      end
      if (!got) begin nchk++; nerr++; $display("FAIL rr_after_reset timeout got no gnt exp gnt=0001"); end
   endtask

   task automatic test_random();
      int wa[4] = '{0, 0, 0, 0};
      int wb[4] = '{0, 0, 0, 0};
      int mxa = 0, mxb = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         nchk++;
         if ({gnt_a, rdata_a, rdy_a} !== {ma.gnt, ma.rdata, ma.wait_n == 0}) begin
            nerr++; $display("FAIL rand_a c=%0d got gnt=%b rdata=%h rdy=%b exp gnt=%b rdata=%h rdy=%b",
                             c, gnt_a, rdata_a, rdy_a, ma.gnt, ma.rdata, ma.wait_n == 0);
         end
         nchk++;
         if ({gnt_b, rdata_b, rdy_b} !== {mb.gnt, mb.rdata, mb.wait_n == 0}) begin
            nerr++; $display("FAIL rand_b c=%0d got gnt=%b rdata=%h rdy=%b exp gnt=%b rdata=%h rdy=%b",
                             c, gnt_b, rdata_b, rdy_b, mb.gnt, mb.rdata, mb.wait_n == 0);
         end
         nchk++;
         if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1) begin
            nerr++; $display("FAIL onehot c=%0d got a=%b b=%b exp at most one bit", c, gnt_a, gnt_b);
         end
         for (int i = 0; i < 4; i++) begin
            wa[i] = (req_a[i] && !gnt_a[i]) ? wa[i] + 1 : 0;
            wb[i] = (req_b[i] && !gnt_b[i]) ? wb[i] + 1 : 0;
            if (wa[i] > mxa) mxa = wa[i];
            if (wb[i] > mxb) mxb = wb[i];
            if (ma.gnt[i]) req_a[i] = 0;
            else if (!req_a[i]) req_a[i] = ($urandom_range(3) == 0);
            else if ($urandom_range(63) == 0) req_a[i] = 0;
            if (mb.gnt[i]) req_b[i] = 0;
            else if (!req_b[i]) req_b[i] = ($urandom_range(3) == 0);
            else if ($urandom_range(63) == 0) req_b[i] = 0;
         end
         sv_a = ($urandom_range(149) == 0);
         sd_a = ($urandom_range(3) == 0) ? '1 : rnd128();
         sv_b = ($urandom_range(149) == 0);
         sd_b = ($urandom_range(3) == 0) ? '1 : rnd128();
      end
      sv_a = 0; sv_b = 0; req_a = '0; req_b = '0;
      nchk++;
      if (mxa >= 60 || mxb >= 60) begin
         nerr++; $display("FAIL starvation got max wait a=%0d b=%0d exp < 60", mxa, mxb);
      end
   endtask

   initial begin
      test_reset();
      test_seed_zero();
      test_back_to_back();
      test_seed_lockup();
      test_seed_vs_req();
      test_reset_mid_gap();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish exp finish before 500000");
      $fatal(1, "watchdog");
   end
endmodule
